// File: rtl/max7219_pkg.sv
// Register map and framing constants shared by the MAX7219 receiver and transmitter.
// A frame is 16 bits, MSB first: [15:12] ignored, [11:8] address, [7:0] data.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOP          = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] ADDR_DECODE_MODE  = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

    localparam int unsigned DIGIT_COUNT = 8;
    localparam logic [4:0]  FRAME_BITS  = 5'd16;

    // Digit registers are addressed 1..8; this maps an address onto digit[0..7].
    function automatic logic [2:0] digit_index(input logic [3:0] addr);
        logic [3:0] idx;
        idx = addr - ADDR_DIGIT0;
        return idx[2:0];
    endfunction

endpackage

// File: rtl/max7219_sync_edge.sv
// Two-flop synchronizer with a third stage for edge detection.
// Edge pulses are registered, so level and the pulses line up in the same cycle.
module max7219_sync_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] stage_q, stage_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    always_comb begin
        stage_d = {stage_q[1:0], async_in};
        rise_d  = stage_q[1] & ~stage_q[2];
        fall_d  = ~stage_q[1] & stage_q[2];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= {3{IDLE}};
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = stage_q[2];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver: shifts 16-bit frames in under cs,
// latches them into the display register bank on cs rising edge.
module max7219_receiver
    import max7219_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_clk,
    input  logic       din,
    input  logic       cs,
    output logic       dout,
    output logic [7:0] digit [0:7],
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    logic spi_lvl, spi_rise, spi_fall;
    logic din_lvl, din_rise, din_fall;
    logic cs_lvl, cs_rise, cs_fall;

    max7219_sync_edge #(.IDLE(1'b0)) u_sync_spi (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (spi_clk),
        .level    (spi_lvl),
        .rise     (spi_rise),
        .fall     (spi_fall)
    );

    max7219_sync_edge #(.IDLE(1'b0)) u_sync_din (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (din),
        .level    (din_lvl),
        .rise     (din_rise),
        .fall     (din_fall)
    );

    max7219_sync_edge #(.IDLE(1'b1)) u_sync_cs (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (cs),
        .level    (cs_lvl),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{spi_lvl, din_rise, din_fall};

    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        dout_q, dout_d;
    logic [7:0]  digit_q [0:7];
    logic [7:0]  digit_d [0:7];
    logic [7:0]  decode_mode_q, decode_mode_d;
    logic [3:0]  intensity_q, intensity_d;
    logic [2:0]  scan_limit_q, scan_limit_d;
    logic        shutdown_n_q, shutdown_n_d;
    logic        display_test_q, display_test_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;

    logic        shift_en;
    logic        latch;
    logic [4:0]  cnt_base;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;

    always_comb begin
        shift_d        = shift_q;
        dout_d         = dout_q;
        digit_d        = digit_q;
        decode_mode_d  = decode_mode_q;
        intensity_d    = intensity_q;
        scan_limit_d   = scan_limit_q;
        shutdown_n_d   = shutdown_n_q;
        display_test_d = display_test_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        wr_strobe_d    = 1'b0;
        frame_err_d    = 1'b0;
        frame_addr     = shift_q[11:8];
        frame_data     = shift_q[7:0];

        // A bit arriving with the cs rise belongs to no frame and is dropped.
        shift_en = spi_rise && !cs_lvl && !cs_rise;
        cnt_base = cs_fall ? '0 : bit_cnt_q;
        bit_cnt_d = cnt_base;
        if (shift_en) begin
            shift_d = {shift_q[14:0], din_lvl};
            if (cnt_base != FRAME_BITS) begin
                bit_cnt_d = cnt_base + 5'd1;
            end
        end

        if (spi_fall) begin
            dout_d = shift_q[15];
        end

        latch = cs_rise && (bit_cnt_q == FRAME_BITS);
        if (cs_rise && !latch) begin
            frame_err_d = 1'b1;
        end

        if (latch) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = frame_addr;
            wr_data_d   = frame_data;
            case (frame_addr)
                ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                    digit_d[digit_index(frame_addr)] = frame_data;
                ADDR_DECODE_MODE:  decode_mode_d  = frame_data;
                ADDR_INTENSITY:    intensity_d    = frame_data[3:0];
                ADDR_SCAN_LIMIT:   scan_limit_d   = frame_data[2:0];
                ADDR_SHUTDOWN:     shutdown_n_d   = frame_data[0];
                ADDR_DISPLAY_TEST: display_test_d = frame_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            dout_q         <= 1'b0;
            for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
                digit_q[i] <= '0;
            end
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
            wr_strobe_q    <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_err_q    <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            dout_q         <= dout_d;
            digit_q        <= digit_d;
            decode_mode_q  <= decode_mode_d;
            intensity_q    <= intensity_d;
            scan_limit_q   <= scan_limit_d;
            shutdown_n_q   <= shutdown_n_d;
            display_test_q <= display_test_d;
            wr_strobe_q    <= wr_strobe_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign dout         = dout_q;
    assign digit        = digit_q;
    assign decode_mode  = decode_mode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_limit_q;
    assign shutdown_n   = shutdown_n_q;
    assign display_test = display_test_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_err    = frame_err_q;

endmodule

// File: doc/max7219_receiver.md
MAX7219_RECEIVER -- requirements
Module: max7219_receiver

Interface
REQ-001 The module SHALL have one clock and one reset: the reset is synchronous and active-low, with ports named clk and reset_n.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 spi_clk  input  1  serial clock from initiator, asynchronous to clk.
REQ-005 din  input  1  serial data, MSB first, valid at spi_clk rising edge.
REQ-006 cs  input  1  load/chip-select, active low; rising edge latches the frame.
REQ-007 dout  output  1  daisy-chain output: din delayed by 16 spi_clk cycles.
REQ-008 digit[8]  output  8 each  digit registers 0..7.
REQ-009 decode_mode / intensity / scan_limit  output  8 / 4 / 3  control registers.
REQ-010 shutdown_n / display_test  output  1 / 1  control bits.
REQ-011 wr_strobe / wr_addr / wr_data  output  1 / 4 / 8  one-cycle pulse per accepted frame, with decoded address and data.
REQ-012 frame_err  output  1  one-cycle pulse when cs rises after fewer than 16 bits.

Function
REQ-013 spi_clk, din and cs SHALL each pass through a 2-flop synchronizer; edges SHALL be detected between the 2nd and a 3rd registered stage.
REQ-014 On a detected spi_clk rising edge with synchronized cs low, the block SHALL shift din into a 16-bit shift register (LSB in) and increment a 5-bit bit counter that saturates at 16.
REQ-015 On a detected spi_clk falling edge, dout SHALL take shift-register bit 15.
REQ-016 On a detected cs falling edge, the bit counter SHALL clear; the shift register SHALL NOT clear.
REQ-017 On a detected cs rising edge with bit counter = 16, the block SHALL latch: addr = shift[11:8], data = shift[7:0]; shift[15:12] is ignored.
REQ-018 Latched addresses SHALL decode as follows:
- 0x0 NOP: no update.
- 0x1-0x8: digit[addr-1] <= data.
- 0x9: decode_mode <= data.
- 0xA: intensity <= data[3:0].
- 0xB: scan_limit <= data[2:0].
- 0xC: shutdown_n <= data[0].
- 0xF: display_test <= data[0].
- 0xD, 0xE: no update.
REQ-019 wr_strobe SHALL pulse for every latched frame, including NOP and ignored addresses.
REQ-020 On a cs rising edge with bit counter < 16, the block SHALL pulse frame_err and leave all registers unchanged.
REQ-021 Latency: register outputs and wr_strobe SHALL change exactly 3 clk cycles after the first clk edge that samples raw cs high.
REQ-022 If a spi_clk rising edge and a cs rising edge are detected in the same cycle, that bit SHALL NOT be shifted.
REQ-023 More than 16 bits in one cs window SHALL latch only the last 16 bits; earlier bits exit on dout.
REQ-024 Input timing: spi_clk high and low phases SHALL each last at least 3 clk periods, and cs SHALL stay high at least 3 clk periods; behaviour outside these limits is undefined.

Reset
REQ-025 While reset_n is low at posedge clk, the block SHALL set:
- digit[*], decode_mode, intensity, scan_limit: 0.
- shutdown_n: 0.
- display_test, dout, wr_strobe, frame_err: 0.
- shift register and bit counter: 0.
- synchronizer stages: idle values (cs = 1, spi_clk = 0, din = 0).
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; the next cs rising edge without 16 fresh bits SHALL raise frame_err.

Structure
REQ-027 Register address constants (NOP, DIGIT0..7, DECODE_MODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, DISPLAY_TEST) SHALL live in a shared package, max7219_pkg, also used by the transmitter.
REQ-028 Synchronizer plus edge detector SHALL be one sub-module, max7219_sync_edge, instantiated for spi_clk, din and cs.

Verification
REQ-029 After reset, send 0x0C01 -> shutdown_n = 1, one wr_strobe with wr_addr = 0xC, wr_data = 0x01, all other registers 0.
REQ-030 Send 0x0305 -> digit[2] = 0x05, all other digits unchanged; then send 0x0D55 -> wr_strobe pulses, no register changes.
REQ-031 Send 32 bits 0x0A0F then 0x0B07 in one cs window -> scan_limit = 7, intensity remains 0, dout carries 0x0A0F during bits 17-32.
REQ-032 Send 10 bits then raise cs -> one frame_err pulse, no wr_strobe, registers unchanged.
REQ-033 Assert reset_n low after 8 bits of 0x0F01, release, send a full 0x0F01 -> display_test = 1, no frame_err.
REQ-034 Check that wr_strobe appears exactly 3 clk cycles after raw cs goes high, with spi_clk at minimum 3-clk phases.
